// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: cause codes, commit_exc_vec bit order,
// FSM states and the priority/cause helper functions.
`timescale 1ns/1ps
`ifndef ExceptionCauseWidth
`define ExceptionCauseWidth 5
`endif

package exc_pkg;

    localparam int unsigned EXC_NUM     = 15;
    localparam int unsigned EXC_CAUSE_W = `ExceptionCauseWidth;

    typedef logic [EXC_CAUSE_W-1:0] exc_cause_t;

    localparam exc_cause_t EXCEPTION_INT  = exc_cause_t'(0);
    localparam exc_cause_t EXCEPTION_PIL  = exc_cause_t'(1);
    localparam exc_cause_t EXCEPTION_PIS  = exc_cause_t'(2);
    localparam exc_cause_t EXCEPTION_PIF  = exc_cause_t'(3);
    localparam exc_cause_t EXCEPTION_PME  = exc_cause_t'(4);
    localparam exc_cause_t EXCEPTION_PPI  = exc_cause_t'(5);
    localparam exc_cause_t EXCEPTION_ADEF = exc_cause_t'(6);
    localparam exc_cause_t EXCEPTION_ADEM = exc_cause_t'(7);
    localparam exc_cause_t EXCEPTION_ALE  = exc_cause_t'(8);
    localparam exc_cause_t EXCEPTION_SYS  = exc_cause_t'(9);
    localparam exc_cause_t EXCEPTION_BRK  = exc_cause_t'(10);
    localparam exc_cause_t EXCEPTION_INE  = exc_cause_t'(11);
    localparam exc_cause_t EXCEPTION_IPE  = exc_cause_t'(12);
    localparam exc_cause_t EXCEPTION_FPD  = exc_cause_t'(13);
    localparam exc_cause_t EXCEPTION_FPE  = exc_cause_t'(14);
    localparam exc_cause_t EXCEPTION_TLBR = exc_cause_t'(15);

    // commit_exc_vec bit positions; lower index has higher priority
    localparam int unsigned EXC_IDX_ADEF = 0;
    localparam int unsigned EXC_IDX_TLBR = 1;
    localparam int unsigned EXC_IDX_PIF  = 2;
    localparam int unsigned EXC_IDX_PPI  = 3;
    localparam int unsigned EXC_IDX_INE  = 4;
    localparam int unsigned EXC_IDX_IPE  = 5;
    localparam int unsigned EXC_IDX_SYS  = 6;
    localparam int unsigned EXC_IDX_BRK  = 7;
    localparam int unsigned EXC_IDX_ALE  = 8;
    localparam int unsigned EXC_IDX_ADEM = 9;
    localparam int unsigned EXC_IDX_PIL  = 10;
    localparam int unsigned EXC_IDX_PIS  = 11;
    localparam int unsigned EXC_IDX_PME  = 12;
    localparam int unsigned EXC_IDX_FPD  = 13;
    localparam int unsigned EXC_IDX_FPE  = 14;

    typedef enum logic [1:0] {IDLE, TRAP, RETN, REDIR} exc_state_e;
    typedef enum logic [1:0] {TGT_EENTRY, TGT_TLBR, TGT_ERA} redir_tgt_e;

    function automatic logic [3:0] exc_first(input logic [EXC_NUM-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = EXC_NUM - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic exc_cause_t exc_idx_to_cause(input logic [3:0] idx);
        exc_cause_t c;
        case (idx)
            4'd0:    c = EXCEPTION_ADEF;
            4'd1:    c = EXCEPTION_TLBR;
            4'd2:    c = EXCEPTION_PIF;
            4'd3:    c = EXCEPTION_PPI;
            4'd4:    c = EXCEPTION_INE;
            4'd5:    c = EXCEPTION_IPE;
            4'd6:    c = EXCEPTION_SYS;
            4'd7:    c = EXCEPTION_BRK;
            4'd8:    c = EXCEPTION_ALE;
            4'd9:    c = EXCEPTION_ADEM;
            4'd10:   c = EXCEPTION_PIL;
            4'd11:   c = EXCEPTION_PIS;
            4'd12:   c = EXCEPTION_PME;
            4'd13:   c = EXCEPTION_FPD;
            4'd14:   c = EXCEPTION_FPE;
            default: c = EXCEPTION_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exc_timer.sv
// TCFG/TVAL countdown timer; raises ti_pend on expiry, cleared through TICLR.
`timescale 1ns/1ps
module exc_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tcfg_we,
    input  logic [31:0] tcfg_wdata,
    input  logic        ticlr_we,
    input  logic [31:0] ticlr_wdata,
    output logic [31:0] tval,
    output logic        ti_pend
);

    logic [31:2] initval_q;
    logic        periodic_q;
    logic        en_q;
    logic        expire;
    logic        unused_ticlr;

    // A TCFG write in the expiry cycle reloads the counter and suppresses the expiry
    assign expire       = en_q & (tval == 32'd0) & ~tcfg_we;
    assign unused_ticlr = ^ticlr_wdata[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initval_q  <= '0;
            periodic_q <= 1'b0;
            en_q       <= 1'b0;
            tval       <= '0;
            ti_pend    <= 1'b0;
        end else begin
            if (tcfg_we) begin
                initval_q  <= tcfg_wdata[31:2];
                periodic_q <= tcfg_wdata[1];
                en_q       <= tcfg_wdata[0];
                tval       <= {tcfg_wdata[31:2], 2'b00};
            end else if (en_q) begin
                if (tval == 32'd0) begin
                    if (periodic_q) begin
                        tval <= {initval_q, 2'b00};
                    end else begin
                        en_q <= 1'b0;
                    end
                end else begin
                    tval <= tval - 32'd1;
                end
            end

            if (expire) begin
                ti_pend <= 1'b1;
            end else if (ticlr_we && ticlr_wdata[0]) begin
                ti_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitrates each commit, strobes the CSR file, flushes and
// redirects the frontend. Timer is built only when EXC_TIMER_EN is defined.
`timescale 1ns/1ps
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned EXC_VEC_W = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            commit_valid,
    output logic                            commit_ready,
    input  logic [31:0]                     commit_pc,
    input  logic [EXC_VEC_W-1:0]            commit_exc_vec,
    input  logic [31:0]                     commit_badv,
    input  logic                            commit_ertn,
    input  logic                            crmd_ie,
    input  logic [12:0]                     ecfg_lie,
    input  logic [1:0]                      estat_sw,
    input  logic [7:0]                      hwi_i,
    input  logic                            ipi_i,
    input  logic [31:0]                     eentry_pc,
    input  logic [31:0]                     tlbrentry_pc,
    input  logic [31:0]                     era_pc,
    input  logic                            tcfg_we,
    input  logic [31:0]                     tcfg_wdata,
    input  logic                            ticlr_we,
    input  logic [31:0]                     ticlr_wdata,
    output logic [31:0]                     tval_o,
    output logic                            is_exception,
    output logic [`ExceptionCauseWidth-1:0] exception_cause,
    output logic [31:0]                     exception_pc,
    output logic [31:0]                     exception_addr,
    output logic                            is_ertn,
    output logic [7:0]                      is_hwi,
    output logic                            is_ti,
    output logic                            is_ipi,
    output logic                            flush,
    output logic                            redirect_valid,
    input  logic                            redirect_ready,
    output logic [31:0]                     redirect_pc
);

    exc_state_e         state_q;
    redir_tgt_e         tgt_q;
    logic               ti_pend;
    logic [12:0]        int_lines;
    logic               int_pend;
    logic [EXC_NUM-1:0] exc_bits;
    logic               exc_any;
    logic [3:0]         exc_idx;
    logic               unused_vec;

    `ifdef EXC_TIMER_EN
    exc_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .tcfg_we     (tcfg_we),
        .tcfg_wdata  (tcfg_wdata),
        .ticlr_we    (ticlr_we),
        .ticlr_wdata (ticlr_wdata),
        .tval        (tval_o),
        .ti_pend     (ti_pend)
    );
    `else
    logic unused_timer;
    assign ti_pend      = 1'b0;
    assign tval_o       = '0;
    assign unused_timer = ^{tcfg_we, tcfg_wdata, ticlr_we, ticlr_wdata};
    `endif

    // Bits at and above EXC_NUM carry no cause and never trap
    assign exc_bits   = commit_exc_vec[EXC_NUM-1:0];
    assign unused_vec = ^(commit_exc_vec >> EXC_NUM);
    assign exc_any    = |exc_bits;
    assign exc_idx    = exc_first(exc_bits);
    assign int_lines  = {ipi_i, ti_pend, 1'b0, hwi_i, estat_sw};
    assign int_pend   = crmd_ie & |(int_lines & ecfg_lie);

    // Target is read live in REDIR so ERTN sees ERA after the CSR update
    always_comb begin
        redirect_pc = '0;
        if (state_q == REDIR) begin
            unique case (tgt_q)
                TGT_TLBR: redirect_pc = tlbrentry_pc;
                TGT_ERA:  redirect_pc = era_pc;
                default:  redirect_pc = eentry_pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            tgt_q           <= TGT_EENTRY;
            commit_ready    <= 1'b1;
            is_exception    <= 1'b0;
            exception_cause <= '0;
            exception_pc    <= '0;
            exception_addr  <= '0;
            is_ertn         <= 1'b0;
            flush           <= 1'b0;
            redirect_valid  <= 1'b0;
            is_hwi          <= '0;
            is_ti           <= 1'b0;
            is_ipi          <= 1'b0;
        end else begin
            is_exception    <= 1'b0;
            is_ertn         <= 1'b0;
            flush           <= 1'b0;
            exception_cause <= '0;
            exception_pc    <= '0;
            exception_addr  <= '0;
            is_hwi          <= hwi_i;
            is_ti           <= ti_pend;
            is_ipi          <= ipi_i;

            unique case (state_q)
                IDLE: begin
                    if (commit_valid && commit_ready) begin
                        if (int_pend || exc_any) begin
                            state_q         <= TRAP;
                            commit_ready    <= 1'b0;
                            is_exception    <= 1'b1;
                            flush           <= 1'b1;
                            exception_cause <= int_pend ? EXCEPTION_INT
                                                        : exc_idx_to_cause(exc_idx);
                            exception_pc    <= commit_pc;
                            exception_addr  <= commit_badv;
                            tgt_q           <= (!int_pend && exc_idx == 4'(EXC_IDX_TLBR))
                                               ? TGT_TLBR : TGT_EENTRY;
                        end else if (commit_ertn) begin
                            state_q      <= RETN;
                            commit_ready <= 1'b0;
                            is_ertn      <= 1'b1;
                            flush        <= 1'b1;
                            tgt_q        <= TGT_ERA;
                        end
                    end
                end
                TRAP, RETN: begin
                    state_q        <= REDIR;
                    redirect_valid <= 1'b1;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        state_q        <= IDLE;
                        redirect_valid <= 1'b0;
                        commit_ready   <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    redirect_valid <= 1'b0;
                    commit_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: randomized commits against a rule-level reference model.
`timescale 1ns/1ps
module tb_exc_ctrl;
    import exc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_valid, commit_ready, commit_ertn;
    logic [31:0] commit_pc, commit_badv;
    logic [15:0] commit_exc_vec;
    logic        crmd_ie;
    logic [12:0] ecfg_lie;
    logic [1:0]  estat_sw;
    logic [7:0]  hwi_i;
    logic        ipi_i;
    logic [31:0] eentry_pc, tlbrentry_pc, era_pc;
    logic        tcfg_we, ticlr_we;
    logic [31:0] tcfg_wdata, ticlr_wdata, tval_o;
    logic        is_exception, is_ertn, is_ti, is_ipi, flush;
    exc_cause_t  exception_cause;
    logic [31:0] exception_pc, exception_addr, redirect_pc;
    logic [7:0]  is_hwi;
    logic        redirect_valid, redirect_ready;

    always #5 clk = ~clk;

    exc_ctrl #(.EXC_VEC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
        .commit_exc_vec(commit_exc_vec), .commit_badv(commit_badv), .commit_ertn(commit_ertn),
        .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_sw(estat_sw), .hwi_i(hwi_i),
        .ipi_i(ipi_i), .eentry_pc(eentry_pc), .tlbrentry_pc(tlbrentry_pc), .era_pc(era_pc),
        .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata), .ticlr_we(ticlr_we),
        .ticlr_wdata(ticlr_wdata), .tval_o(tval_o), .is_exception(is_exception),
        .exception_cause(exception_cause), .exception_pc(exception_pc),
        .exception_addr(exception_addr), .is_ertn(is_ertn), .is_hwi(is_hwi), .is_ti(is_ti),
        .is_ipi(is_ipi), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
    );

    typedef struct {
        int          kind;   // 1 = trap, 2 = ertn
        exc_cause_t  cause;
        logic [31:0] pc, addr, target;
        logic [7:0]  hwi;
        logic        ipi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   exp_handshakes = 0, handshakes = 0, last_wait = 0;
    logic rr_mode = 1'b0, rr_force = 1'b0;

    // cause for each commit_exc_vec bit, in priority order
    exc_cause_t cause_tbl [15] = '{EXCEPTION_ADEF, EXCEPTION_TLBR, EXCEPTION_PIF, EXCEPTION_PPI,
        EXCEPTION_INE, EXCEPTION_IPE, EXCEPTION_SYS, EXCEPTION_BRK, EXCEPTION_ALE,
        EXCEPTION_ADEM, EXCEPTION_PIL, EXCEPTION_PIS, EXCEPTION_PME, EXCEPTION_FPD,
        EXCEPTION_FPE};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model (timer idle, so the timer interrupt line is 0)
    function automatic exp_t model(input logic [31:0] pc, badv, input logic [15:0] vec,
                                   input logic ertn, ie, input logic [12:0] lie,
                                   input logic [1:0] sw, input logic [7:0] hwi,
                                   input logic ipi, input logic [31:0] ee, tl, er);
        exp_t e;
        logic [12:0] lines;
        int first;
        e = '{kind: 0, cause: EXCEPTION_INT, pc: pc, addr: badv, target: ee, hwi: hwi,
              ipi: ipi};
        lines = {ipi, 1'b0, 1'b0, hwi, sw};
        first = -1;
        for (int i = 14; i >= 0; i--) if (vec[i]) first = i;
        if (ie && (lines & lie) != 13'd0) begin
            e.kind = 1;
        end else if (first >= 0) begin
            e.kind   = 1;
            e.cause  = cause_tbl[first];
            e.target = (first == 1) ? tl : ee;
        end else if (ertn) begin
            e.kind   = 2;
            e.target = er;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!commit_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!commit_ready) chk("commit_ready_timeout", 32'(commit_ready), 32'd1);
    endtask

    task automatic issue(input logic [31:0] pc, badv, input logic [15:0] vec,
                         input logic ertn, ie, input logic [12:0] lie, input logic [1:0] sw,
                         input logic [7:0] hwi, input logic ipi,
                         input logic [31:0] ee, tl, er);
        exp_t e;
        wait_ready();
        if (!commit_ready) return;
        commit_pc = pc; commit_badv = badv; commit_exc_vec = vec; commit_ertn = ertn;
        crmd_ie = ie; ecfg_lie = lie; estat_sw = sw; hwi_i = hwi; ipi_i = ipi;
        eentry_pc = ee; tlbrentry_pc = tl; era_pc = er;
        commit_valid = 1'b1;
        e = model(pc, badv, vec, ertn, ie, lie, sw, hwi, ipi, ee, tl, er);
        if (e.kind != 0) begin
            exp_q.push_back(e);
            exp_handshakes++;
        end
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    initial begin
        redirect_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            redirect_ready = rr_mode ? rr_force : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on each strobe and follows the redirect
    initial begin
        logic prev_strobe, have_cur, strobe;
        exp_t cur;
        int   waitc;
        prev_strobe = 1'b0; have_cur = 1'b0; waitc = 0;
        forever begin
            @(posedge clk); #4;
            if (!rst_n) begin
                prev_strobe = 1'b0; have_cur = 1'b0; waitc = 0;
                continue;
            end
            strobe = is_exception | is_ertn;
            if (strobe) begin
                if (prev_strobe) chk("strobe_back_to_back", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(strobe), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1; waitc = 0;
                    chk("strobe_kind", is_exception ? 32'd1 : 32'd2, 32'(cur.kind));
                    chk("flush_with_strobe", 32'(flush), 32'd1);
                    chk("commit_ready_in_strobe", 32'(commit_ready), 32'd0);
                    if (cur.kind == 1) begin
                        chk("exception_cause", 32'(exception_cause), 32'(cur.cause));
                        chk("exception_pc", exception_pc, cur.pc);
                        chk("exception_addr", exception_addr, cur.addr);
                        chk("is_hwi", 32'(is_hwi), 32'(cur.hwi));
                        chk("is_ipi", 32'(is_ipi), 32'(cur.ipi));
                    end
                end
            end else if (flush) begin
                chk("flush_without_strobe", 32'(flush), 32'd0);
            end
            if (redirect_valid) begin
                if (commit_ready) chk("commit_ready_in_redirect", 32'(commit_ready), 32'd0);
                if (!have_cur) begin
                    chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
                end else begin
                    chk("redirect_pc", redirect_pc, cur.target);
                    if (redirect_ready) begin
                        last_wait = waitc;
                        handshakes++;
                        have_cur = 1'b0;
                    end else begin
                        waitc++;
                    end
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        commit_valid = 0; commit_ertn = 0; commit_pc = 0; commit_badv = 0; commit_exc_vec = 0;
        crmd_ie = 0; ecfg_lie = 0; estat_sw = 0; hwi_i = 0; ipi_i = 0;
        eentry_pc = 0; tlbrentry_pc = 0; era_pc = 0;
        tcfg_we = 0; tcfg_wdata = 0; ticlr_we = 0; ticlr_wdata = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        chk("reset_commit_ready", 32'(commit_ready), 32'd1);
        chk("reset_strobes", 32'({is_exception, is_ertn, flush, redirect_valid}), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_tval", tval_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: SYS trap, ADEF over ALE, interrupt vs masked interrupt
        issue(32'h1c000010, 32'h0, 16'h0040, 0, 0, 13'h0, 2'b0, 8'h0, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        issue(32'h1c000020, 32'hdeadbeef, 16'h0101, 0, 0, 13'h0, 2'b0, 8'h0, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        issue(32'h1c000030, 32'h0, 16'h0040, 0, 1, 13'h004, 2'b0, 8'h01, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        issue(32'h1c000040, 32'h0, 16'h0040, 0, 0, 13'h004, 2'b0, 8'h01, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        issue(32'h1c000050, 32'h1234, 16'h0002, 0, 0, 13'h0, 2'b0, 8'h0, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);

        // Directed: ERTN with redirect_ready held low for three cycles
        wait_ready();
        rr_force = 1'b0; rr_mode = 1'b1;
        issue(32'h1c000060, 32'h0, 16'h0, 1, 0, 13'h0, 2'b0, 8'h0, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        repeat (3) @(posedge clk);
        @(negedge clk) rr_force = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ertn_redirect_wait", 32'(last_wait), 32'd3);
        rr_mode = 1'b0;

        // Randomized commits
        for (int t = 0; t < 80; t++) begin
            logic [15:0] vec;
            int mode;
            mode = $urandom_range(0, 3);
            vec = (mode == 0) ? 16'h0 :
                  (mode == 1) ? 16'(1 << $urandom_range(0, 14)) :
                  16'($urandom) & 16'h7fff & 16'($urandom);
            issue($urandom, $urandom, vec, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 13'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom), $urandom, $urandom, $urandom);
        end

        // Reset while in REDIR drops the redirect immediately
        wait_ready();
        rr_force = 1'b0; rr_mode = 1'b1;
        issue(32'h1c000070, 32'h0, 16'h0080, 0, 0, 13'h0, 2'b0, 8'h0, 0,
              32'h1c008000, 32'h1c00f000, 32'h1c000014);
        exp_handshakes--;
        @(posedge clk); #3;
        chk("redir_before_reset", 32'(redirect_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_redir_commit_ready", 32'(commit_ready), 32'd1);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_redir_strobes", 32'({is_exception, is_ertn, flush, is_ti, is_ipi}), 32'd0);
        chk("rst_redir_fields", exception_pc | exception_addr | 32'(exception_cause)
                                | 32'(is_hwi), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        rr_mode = 1'b0;
        @(posedge clk); #1;

`ifdef EXC_TIMER_EN
        // Periodic timer, initval=2: 8..0, expiry beats a same-cycle clear, then reload
        tcfg_we = 1'b1; tcfg_wdata = 32'h0000000b;
        @(posedge clk); #1;
        tcfg_we = 1'b0;
        for (int k = 8; k >= 1; k--) begin
            chk("tval_periodic", tval_o, 32'(k));
            @(posedge clk); #1;
        end
        chk("tval_zero", tval_o, 32'd0);
        chk("ti_before_expiry", 32'(is_ti), 32'd0);
        ticlr_we = 1'b1; ticlr_wdata = 32'h1;
        @(posedge clk); #1;
        ticlr_we = 1'b0;
        chk("tval_reload", tval_o, 32'd8);
        @(posedge clk); #1;
        chk("ti_set_beats_clear", 32'(is_ti), 32'd1);
        ticlr_we = 1'b1;
        @(posedge clk); #1;
        ticlr_we = 1'b0;
        @(posedge clk); #1;
        chk("ti_cleared", 32'(is_ti), 32'd0);
        // One-shot, initval=1: 4..0, fires once, holds 0
        tcfg_we = 1'b1; tcfg_wdata = 32'h00000005;
        @(posedge clk); #1;
        tcfg_we = 1'b0;
        chk("tval_oneshot_load", tval_o, 32'd4);
        repeat (6) @(posedge clk);
        #1;
        chk("tval_oneshot_hold", tval_o, 32'd0);
        chk("ti_oneshot", 32'(is_ti), 32'd1);
        ticlr_we = 1'b1;
        @(posedge clk); #1;
        ticlr_we = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ti_oneshot_no_refire", 32'(is_ti), 32'd0);
        chk("tval_oneshot_stays", tval_o, 32'd0);
        tcfg_we = 1'b1; tcfg_wdata = 32'h0;
        @(posedge clk); #1;
        tcfg_we = 1'b0;
`else
        // Without the timer, TCFG writes have no visible effect
        tcfg_we = 1'b1; tcfg_wdata = 32'h0000000b;
        @(posedge clk); #1;
        tcfg_we = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_timer_tval", tval_o, 32'd0);
        chk("no_timer_ti", 32'(is_ti), 32'd0);
`endif

        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("handshake_count", 32'(handshakes), 32'(exp_handshakes));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
